// File: rtl/axi_sram_slave.sv
// AXI3 slave that serves one read or write burst at a time from a synchronous SRAM
// whose read data appears the cycle after the enable.
module axi_sram_slave #(
  parameter int ID_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [31:0]         awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_WIDTH-1:0] wid,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                sram_en,
  output logic [3:0]          sram_wen,
  output logic [31:0]         sram_addr,
  output logic [31:0]         sram_wdata,
  input  logic [31:0]         sram_rdata,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RREQ  = 3'd1,
    RCAP  = 3'd2,
    RRESP = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         rbuf_q, rbuf_d;
  logic [3:0]          len_q, len_d;
  logic [3:0]          beat_q, beat_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic                err_q, err_d;
  logic                last_write_q, last_write_d;
  logic [31:0]         next_addr;
  logic                grant_r, grant_w, last_beat, w_fire;
  logic                unused_wid;

  assign unused_wid = ^wid;

  // A transfer happens on a rising edge where valid and ready are both high; once a
  // valid is raised its payload is held and the valid is kept until the matching ready.
  assign grant_r = ~awvalid | last_write_q;
  assign grant_w = ~arvalid | ~last_write_q;
  assign arready = (state_q == IDLE) & arvalid & grant_r & ~reset;
  assign awready = (state_q == IDLE) & awvalid & grant_w & ~reset;

  assign last_beat = (beat_q == len_q);
  assign w_fire    = (state_q == WDATA) & wvalid;
  assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);

  assign rvalid = (state_q == RRESP);
  assign rdata  = rbuf_q;
  assign rid    = id_q;
  assign rresp  = err_q ? 2'b10 : 2'b00;
  assign rlast  = (state_q == RRESP) & last_beat;
  assign wready = (state_q == WDATA);
  assign bvalid = (state_q == WRESP);
  assign bid    = id_q;
  assign bresp  = err_q ? 2'b10 : 2'b00;

  assign sram_en    = (state_q == RREQ) | w_fire;
  assign sram_wen   = w_fire ? wstrb : 4'b0000;
  assign sram_addr  = {addr_q[31:2], 2'b00};
  assign sram_wdata = wdata;
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    rbuf_d       = rbuf_q;
    len_d        = len_q;
    beat_d       = beat_q;
    size_d       = size_q;
    burst_d      = burst_q;
    err_d        = err_q;
    last_write_d = last_write_q;
    case (state_q)
      IDLE: begin
        if (arready) begin
          id_d         = arid;
          addr_d       = araddr;
          len_d        = arlen;
          size_d       = arsize;
          burst_d      = arburst;
          beat_d       = 4'd0;
          err_d        = (arburst == 2'b10);
          last_write_d = 1'b0;
          state_d      = RREQ;
        end else if (awready) begin
          id_d         = awid;
          addr_d       = awaddr;
          len_d        = awlen;
          size_d       = awsize;
          burst_d      = awburst;
          beat_d       = 4'd0;
          err_d        = (awburst == 2'b10);
          last_write_d = 1'b1;
          state_d      = WDATA;
        end
      end
      RREQ: state_d = RCAP;
      RCAP: begin
        rbuf_d  = sram_rdata;
        state_d = RRESP;
      end
      RRESP: begin
        if (rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 4'd1;
            addr_d  = next_addr;
            state_d = RREQ;
          end
        end
      end
      WDATA: begin
        if (wvalid) begin
          // The burst length comes from awlen; wlast only flags a protocol error.
          if (last_beat) begin
            err_d   = err_q | ~wlast;
            state_d = WRESP;
          end else begin
            err_d  = err_q | wlast;
            beat_d = beat_q + 4'd1;
            addr_d = next_addr;
          end
        end
      end
      WRESP: begin
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      id_q         <= '0;
      addr_q       <= 32'd0;
      rbuf_q       <= 32'd0;
      len_q        <= 4'd0;
      beat_q       <= 4'd0;
      size_q       <= 3'd0;
      burst_q      <= 2'b00;
      err_q        <= 1'b0;
      last_write_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      rbuf_q       <= rbuf_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      err_q        <= err_d;
      last_write_q <= last_write_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed and randomized bursts against axi_sram_slave, with a word-array SRAM device
// and a reference memory updated from the burst addressing rules.
module tb_axi_sram_slave;
  localparam int ID_WIDTH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [ID_WIDTH-1:0] arid, awid, wid, rid, bid;
  logic [31:0]         araddr, awaddr;
  logic [3:0]          arlen, awlen;
  logic [2:0]          arsize, awsize;
  logic [1:0]          arburst, awburst;
  logic                arvalid, arready, awvalid, awready;
  logic [31:0]         rdata;
  logic [1:0]          rresp, bresp;
  logic                rlast, rvalid, rready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast, wvalid, wready;
  logic                bvalid, bready;
  logic                sram_en;
  logic [3:0]          sram_wen;
  logic [31:0]         sram_addr, sram_wdata, sram_rdata;
  logic [2:0]          dbg_state;

  axi_sram_slave #(.ID_WIDTH(ID_WIDTH)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- SRAM device and reference memory ----------------
  logic [31:0] sram_mem [1024];
  logic [31:0] ref_mem  [1024];
  logic        fill, bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;

  function automatic logic [31:0] pat(int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h7F4A_7C15;
  endfunction

  always @(posedge clk) begin
    if (sram_en && sram_wen == 4'b0000) sram_rdata <= sram_mem[sram_addr[11:2]];
    else sram_rdata <= $urandom;
    if (fill) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= pat(i);
    end else if (bd_we) begin
      sram_mem[bd_idx] <= bd_data;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) sram_mem[sram_addr[11:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  function automatic logic [31:0] beat_addr(logic [31:0] a0, int i, logic [2:0] size,
                                            logic [1:0] burst);
    return (burst == 2'b00) ? a0 : a0 + (32'(i) << size);
  endfunction

  // ---------------- transaction context ----------------
  logic [3:0]  rd_id, wr_id, rd_len, wr_len;
  logic [31:0] rd_addr, wr_addr, first_rdata;
  logic [2:0]  rd_size, wr_size;
  logic [1:0]  rd_burst, wr_burst;
  logic [31:0] wbuf_data [16];
  logic [3:0]  wbuf_strb [16];
  logic        wbuf_last [16];
  int          wgap [16];
  int unsigned hs_cyc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(int idx, logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = 10'(idx); bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = d;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ar();
    arid = rd_id; araddr = rd_addr; arlen = rd_len; arsize = rd_size; arburst = rd_burst;
    arvalid = 1'b1;
  endtask

  task automatic set_aw();
    awid = wr_id; awaddr = wr_addr; awlen = wr_len; awsize = wr_size; awburst = wr_burst;
    awvalid = 1'b1;
  endtask

  task automatic ar_handshake();
    int n;
    n = 0;
    #1;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    chk("ar_accept", arready, 1);
    hs_cyc = cyc;
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic aw_handshake();
    int n;
    n = 0;
    #1;
    while (!awready && n < 50) begin @(negedge clk); #1; n++; end
    chk("aw_accept", awready, 1);
    hs_cyc = cyc;
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic r_collect(int abort_beat);
    logic [31:0] a, exp_d;
    int n, d;
    for (int i = 0; i <= int'(rd_len); i++) begin
      a = beat_addr(rd_addr, i, rd_size, rd_burst);
      exp_d = ref_mem[a[11:2]];
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      chk("r_valid", rvalid, 1);
      chk("r_latency", cyc - hs_cyc, 3);
      if (i == abort_beat) begin
        reset = 1'b1; arvalid = 1'b1; #1;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_arready", arready, 0);
        chk("rst_state", dbg_state, 0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_hold_sram_en", sram_en, 0);
          chk("rst_hold_rvalid", rvalid, 0);
        end
        arvalid = 1'b0; reset = 1'b0;
        return;
      end
      if (i == 0) first_rdata = rdata;
      chk("r_data", rdata, exp_d);
      chk("r_id", rid, rd_id);
      chk("r_resp", rresp, (rd_burst == 2'b10) ? 32'd2 : 32'd0);
      chk("r_last", rlast, (i == int'(rd_len)) ? 32'd1 : 32'd0);
      d = $urandom_range(0, 2);
      repeat (d) begin
        @(negedge clk);
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", rdata, exp_d);
      end
      rready = 1'b1;
      hs_cyc = cyc;
      @(negedge clk);
      rready = 1'b0;
    end
    chk("r_done", rvalid, 0);
    chk("r_idle", dbg_state, 0);
  endtask

  task automatic w_send(int bdelay);
    logic [31:0] a;
    logic        err;
    err = (wr_burst == 2'b10);
    chk("w_ready_start", wready, 1);
    chk("w_ready_latency", cyc - hs_cyc, 1);
    for (int i = 0; i <= int'(wr_len); i++) begin
      a = beat_addr(wr_addr, i, wr_size, wr_burst);
      repeat (wgap[i]) begin
        wvalid = 1'b0; #1;
        chk("w_gap_ready", wready, 1);
        chk("w_gap_sram_en", sram_en, 0);
        @(negedge clk);
      end
      wvalid = 1'b1; wdata = wbuf_data[i]; wstrb = wbuf_strb[i]; wlast = wbuf_last[i]; #1;
      chk("w_sram_en", sram_en, 1);
      chk("w_sram_wen", sram_wen, wbuf_strb[i]);
      chk("w_sram_addr", sram_addr, {a[31:2], 2'b00});
      chk("w_sram_wdata", sram_wdata, wbuf_data[i]);
      for (int b = 0; b < 4; b++)
        if (wbuf_strb[i][b]) ref_mem[a[11:2]][8*b +: 8] = wbuf_data[i][8*b +: 8];
      if (i == int'(wr_len)) err = err | ~wbuf_last[i];
      else err = err | wbuf_last[i];
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("b_valid", bvalid, 1);
    chk("b_id", bid, wr_id);
    chk("b_resp", bresp, err ? 32'd2 : 32'd0);
    repeat (bdelay) begin
      @(negedge clk);
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_resp", bresp, err ? 32'd2 : 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_done", bvalid, 0);
    chk("b_idle", dbg_state, 0);
  endtask

  task automatic fill_wbuf_random();
    for (int i = 0; i < 16; i++) begin
      wbuf_data[i] = $urandom;
      wbuf_strb[i] = 4'($urandom_range(0, 15));
      wbuf_last[i] = (i == int'(wr_len)) ^ ($urandom_range(0, 7) == 0);
      wgap[i]      = $urandom_range(0, 2);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int mism;
    reset = 1'b1; fill = 1'b1; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    arvalid = 0; awvalid = 0; rready = 0; wvalid = 0; bready = 0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    repeat (2) @(negedge clk);
    fill = 1'b0;

    // Reset values, with requests pending that must not be accepted.
    arvalid = 1'b1; awvalid = 1'b1; #1;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_wen", sram_wen, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_state", dbg_state, 0);
    arvalid = 1'b0; awvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    preload(32'h100 >> 2, 32'hDEAD_BEEF);

    // First tie after reset: single read wins, then the backpressured INCR write.
    rd_id = 4'd3; rd_addr = 32'h100; rd_len = 4'd0; rd_size = 3'd2; rd_burst = 2'b01;
    wr_id = 4'd5; wr_addr = 32'h200; wr_len = 4'd3; wr_size = 3'd2; wr_burst = 2'b01;
    for (int i = 0; i < 4; i++) begin
      wbuf_data[i] = 32'(i + 1); wbuf_strb[i] = 4'b1111; wbuf_last[i] = (i == 3);
    end
    wgap[0] = 1; wgap[1] = 0; wgap[2] = 2; wgap[3] = 1;
    @(negedge clk);
    set_ar(); set_aw(); #1;
    chk("tie1_arready", arready, 1);
    chk("tie1_awready", awready, 0);
    ar_handshake();
    #1 chk("tie1_aw_blocked", awready, 0);
    r_collect(-1);
    chk("plan_read_data", first_rdata, 32'hDEAD_BEEF);
    #1 chk("tie1_aw_next", awready, 1);
    aw_handshake();
    w_send(5);
    for (int i = 0; i < 4; i++) chk("plan_incr_word", sram_mem[(32'h200 >> 2) + i], 32'(i + 1));

    // FIXED burst with byte strobes onto one word.
    preload(32'h300 >> 2, 32'h1122_3344);
    wr_id = 4'd8; wr_addr = 32'h300; wr_len = 4'd1; wr_size = 3'd2; wr_burst = 2'b00;
    wbuf_data[0] = 32'h0000_00AA; wbuf_strb[0] = 4'b0001; wbuf_last[0] = 1'b0; wgap[0] = 0;
    wbuf_data[1] = 32'hBB00_0000; wbuf_strb[1] = 4'b1000; wbuf_last[1] = 1'b1; wgap[1] = 0;
    @(negedge clk);
    set_aw(); aw_handshake(); w_send(0);
    chk("plan_fixed_word", sram_mem[32'h300 >> 2], 32'hBB22_33AA);

    // A plain read, so the next tie goes to the write.
    rd_id = 4'd1; rd_addr = 32'h400; rd_len = 4'd2; rd_size = 3'd2; rd_burst = 2'b01;
    @(negedge clk);
    set_ar(); ar_handshake(); r_collect(-1);

    rd_id = 4'd6; rd_addr = 32'h500; rd_len = 4'd1; rd_size = 3'd2; rd_burst = 2'b01;
    wr_id = 4'd9; wr_addr = 32'h600; wr_len = 4'd1; wr_size = 3'd2; wr_burst = 2'b01;
    fill_wbuf_random();
    wbuf_last[0] = 1'b0; wbuf_last[1] = 1'b1;
    @(negedge clk);
    set_ar(); set_aw(); #1;
    chk("tie2_awready", awready, 1);
    chk("tie2_arready", arready, 0);
    aw_handshake();
    #1 chk("tie2_ar_blocked", arready, 0);
    w_send(1);
    #1 chk("tie2_ar_next", arready, 1);
    ar_handshake();
    r_collect(-1);

    // WRAP read is answered with SLVERR on every beat.
    rd_id = 4'd2; rd_addr = 32'h700; rd_len = 4'd1; rd_size = 3'd2; rd_burst = 2'b10;
    @(negedge clk);
    set_ar(); ar_handshake(); r_collect(-1);

    // Early wlast: all three beats still taken, SLVERR on B.
    wr_id = 4'd10; wr_addr = 32'h740; wr_len = 4'd2; wr_size = 3'd2; wr_burst = 2'b01;
    for (int i = 0; i < 3; i++) begin
      wbuf_data[i] = 32'hC0DE_0000 + 32'(i); wbuf_strb[i] = 4'b1111; wgap[i] = 0;
    end
    wbuf_last[0] = 1'b0; wbuf_last[1] = 1'b1; wbuf_last[2] = 1'b1;
    @(negedge clk);
    set_aw(); aw_handshake(); w_send(2);

    // Randomized bursts.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        rd_id = 4'($urandom_range(0, 15)); rd_len = 4'($urandom_range(0, 15));
        rd_size = 3'($urandom_range(0, 2)); rd_burst = 2'($urandom_range(0, 2));
        rd_addr = $urandom_range(0, 32'hD00);
        @(negedge clk);
        set_ar(); ar_handshake(); r_collect(-1);
      end else begin
        wr_id = 4'($urandom_range(0, 15)); wr_len = 4'($urandom_range(0, 15));
        wr_size = 3'($urandom_range(0, 2)); wr_burst = 2'($urandom_range(0, 2));
        wr_addr = $urandom_range(0, 32'hD00);
        fill_wbuf_random();
        @(negedge clk);
        set_aw(); aw_handshake(); w_send($urandom_range(0, 3));
      end
    end

    // Reset during beat 2 of a 4-beat read, then a clean single read.
    rd_id = 4'd4; rd_addr = 32'h800; rd_len = 4'd3; rd_size = 3'd2; rd_burst = 2'b01;
    @(negedge clk);
    set_ar(); ar_handshake(); r_collect(1);
    rd_id = 4'd7; rd_addr = 32'h100; rd_len = 4'd0; rd_size = 3'd2; rd_burst = 2'b01;
    @(negedge clk);
    set_ar(); ar_handshake(); r_collect(-1);

    mism = 0;
    for (int i = 0; i < 1024; i++) if (sram_mem[i] !== ref_mem[i]) mism++;
    chk("mem_final_mismatches", 32'(mism), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
